psum_op_dispatcher: RTL and testbench

- Initiator-side partner of psum_manager.
- Accepts sequence-pair commands (seq1, seq2) from an upstream controller into a small queue and allocates operation IDs.
- Drives the new_op_request handshake into the psum manager, honours stall and assign_valid, and tracks in-flight operations with their assigned bank.
- Retires operations on op_done/op_done_id and reports each completion upstream.

---
 rtl/psum_op_dispatcher.sv | 213 +++++++++++++++++++++
 tb/tb_psum_op_dispatcher.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_op_dispatcher.sv
// psum_op_dispatcher: queues sequence-pair commands, issues them to the psum manager and tracks them until op_done.
// Optional macro PSUM_DISPATCH_LATENCY_EN adds per-entry latency counters and the done_latency output.
module psum_op_dispatcher #(
  parameter int ADDR_WIDTH      = 8,
  parameter int OP_ID_WIDTH     = 8,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ASSIGN_TIMEOUT  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [ADDR_WIDTH-1:0]             cmd_seq1,
  input  logic [15:0]                       cmd_seq2,
  output logic                              new_op_request,
  output logic [ADDR_WIDTH-1:0]             seq1,
  output logic [15:0]                       seq2,
  output logic [OP_ID_WIDTH-1:0]            operation_id,
  input  logic                              assign_valid,
  input  logic [2:0]                        selected_bank,
  input  logic                              stall,
  input  logic                              op_done,
  input  logic [OP_ID_WIDTH-1:0]            op_done_id,
  output logic                              done_valid,
  output logic [OP_ID_WIDTH-1:0]            done_id,
  output logic [2:0]                        done_bank,
`ifdef PSUM_DISPATCH_LATENCY_EN
  output logic [15:0]                       done_latency,
`endif
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              busy,
  output logic                              err_unknown_id,
  output logic                              err_timeout
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int TW = $clog2(ASSIGN_TIMEOUT + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ASSIGN, BACKOFF} state_t;

  logic [ADDR_WIDTH-1:0]  q_seq1 [QUEUE_DEPTH];
  logic [15:0]            q_seq2 [QUEUE_DEPTH];
  logic [QW-1:0]          wr_ptr, rd_ptr;
  logic [QW:0]            q_count;
  logic                   push, pop;

  state_t                 state, state_next;
  logic [TW-1:0]          timer;
  logic [OP_ID_WIDTH-1:0] next_id;
  logic                   assign_fire, timeout_hit, table_wr;

  logic [MAX_OUTSTANDING-1:0] t_valid;
  logic [OP_ID_WIDTH-1:0]     t_id   [MAX_OUTSTANDING];
  logic [2:0]                 t_bank [MAX_OUTSTANDING];
  logic                       free_found, hit;
  logic [IW-1:0]              free_idx, hit_idx;

  assign cmd_ready      = (q_count != (QW+1)'(QUEUE_DEPTH));
  assign push           = cmd_valid && cmd_ready;
  assign pop            = assign_fire;
  assign new_op_request = (state == ISSUE);
  assign seq1           = (state != IDLE) ? q_seq1[rd_ptr] : '0;
  assign seq2           = (state != IDLE) ? q_seq2[rd_ptr] : '0;
  assign operation_id   = (state != IDLE) ? next_id : '0;
  assign busy           = (q_count != '0) || (state != IDLE) || (outstanding != '0);
  assign table_wr       = assign_fire && free_found;

  always_ff @(posedge clk) begin
    if (push) begin
      q_seq1[wr_ptr] <= cmd_seq1;
      q_seq2[wr_ptr] <= cmd_seq2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop)  rd_ptr <= rd_ptr + QW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + (QW+1)'(1);
        2'b01:   q_count <= q_count - (QW+1)'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    assign_fire = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:
        if ((q_count != '0) && (outstanding < OW'(MAX_OUTSTANDING)) && !stall)
          state_next = ISSUE;
      ISSUE:
        if (assign_valid) begin
          assign_fire = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next  = WAIT_ASSIGN;
        end
      WAIT_ASSIGN:
        if (assign_valid) begin
          assign_fire = 1'b1;
          state_next  = IDLE;
        end else if (stall) begin
          state_next  = BACKOFF;
        end else if (timer == TW'(ASSIGN_TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_next  = BACKOFF;
        end
      BACKOFF:
        if (!stall) state_next = ISSUE;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      next_id     <= OP_ID_WIDTH'(1);
      err_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ISSUE)            timer <= TW'(1);
      else if (state == WAIT_ASSIGN) timer <= timer + TW'(1);
      // ID 0 is reserved, so the counter wraps from all-ones back to 1.
      if (assign_fire)
        next_id <= (next_id == '1) ? OP_ID_WIDTH'(1) : next_id + OP_ID_WIDTH'(1);
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

  // Free-slot search uses the pre-retire valid bits, so a slot freed this cycle is reused no earlier than next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!t_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (op_done && t_valid[i] && (t_id[i] == op_done_id) && !hit) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_valid        <= '0;
      outstanding    <= '0;
      done_valid     <= 1'b0;
      done_id        <= '0;
      done_bank      <= '0;
      err_unknown_id <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        t_id[i]   <= '0;
        t_bank[i] <= '0;
      end
    end else begin
      if (table_wr) begin
        t_valid[free_idx] <= 1'b1;
        t_id[free_idx]    <= next_id;
        t_bank[free_idx]  <= selected_bank;
      end
      if (hit) begin
        t_valid[hit_idx] <= 1'b0;
        done_id          <= op_done_id;
        done_bank        <= t_bank[hit_idx];
      end
      done_valid <= hit;
      if (op_done && !hit) err_unknown_id <= 1'b1;
      case ({table_wr, hit})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef PSUM_DISPATCH_LATENCY_EN
  logic [15:0] t_lat [MAX_OUTSTANDING];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_latency <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) t_lat[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (table_wr && (free_idx == IW'(i)))
          t_lat[i] <= 16'd1;
        else if (t_valid[i] && (t_lat[i] != 16'hFFFF))
          t_lat[i] <= t_lat[i] + 16'd1;
      end
      if (hit) done_latency <= t_lat[hit_idx];
    end
  end
`endif

endmodule

// File: tb/tb_psum_op_dispatcher.sv
// tb_psum_op_dispatcher: scoreboard bench for psum_op_dispatcher (request and completion queues, bench-side ID model).
module tb_psum_op_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_seq1;
  logic [15:0] cmd_seq2;
  logic        new_op_request;
  logic [7:0]  seq1;
  logic [15:0] seq2;
  logic [7:0]  operation_id;
  logic        assign_valid;
  logic [2:0]  selected_bank;
  logic        stall, op_done;
  logic [7:0]  op_done_id;
  logic        done_valid;
  logic [7:0]  done_id;
  logic [2:0]  done_bank;
`ifdef PSUM_DISPATCH_LATENCY_EN
  logic [15:0] done_latency;
`endif
  logic [2:0]  outstanding;
  logic        busy, err_unknown_id, err_timeout;

  typedef struct { logic [7:0] s1; logic [15:0] s2; } cmd_t;
  typedef struct { logic [7:0] id; logic [2:0] bank; } done_t;

  cmd_t       exp_req_q [$];
  done_t      exp_done_q [$];
  logic [2:0] bank_of [int];
  logic [7:0] model_id;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_req_cyc = 0;

  psum_op_dispatcher dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seq1(cmd_seq1), .cmd_seq2(cmd_seq2),
    .new_op_request(new_op_request), .seq1(seq1), .seq2(seq2), .operation_id(operation_id),
    .assign_valid(assign_valid), .selected_bank(selected_bank), .stall(stall),
    .op_done(op_done), .op_done_id(op_done_id),
    .done_valid(done_valid), .done_id(done_id), .done_bank(done_bank),
`ifdef PSUM_DISPATCH_LATENCY_EN
    .done_latency(done_latency),
`endif
    .outstanding(outstanding), .busy(busy),
    .err_unknown_id(err_unknown_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    exp_req_q.delete();
    exp_done_q.delete();
    bank_of.delete();
    model_id = 8'd1;
  endtask

  task automatic do_reset;
    cmd_valid = 0; cmd_seq1 = 0; cmd_seq2 = 0; assign_valid = 0; selected_bank = 0;
    stall = 0; op_done = 0; op_done_id = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_clear();
  endtask

  task automatic push_cmd(input logic [7:0] s1, input logic [15:0] s2);
    cmd_t c;
    for (int n = 0; n < 50 && !cmd_ready; n++) step();
    if (!cmd_ready) begin
      checks++; errors++;
      $display("[TB] FAIL push_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid = 1; cmd_seq1 = s1; cmd_seq2 = s2;
    step();
    cmd_valid = 0;
    c.s1 = s1; c.s2 = s2;
    exp_req_q.push_back(c);
  endtask

  task automatic wait_req(output bit seen);
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (new_op_request) begin
        seen = 1;
        break;
      end
      step();
    end
  endtask

  task automatic issue_and_assign(input logic [2:0] bank, input int delay, input string tag);
    bit   seen;
    cmd_t e;
    cmd_t d;
    wait_req(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_req: new_op_request=0 required 1", tag);
    end else begin
      last_req_cyc = cyc;
      e.s1 = 0; e.s2 = 0;
      if (exp_req_q.size() > 0) e = exp_req_q[0];
      if (exp_req_q.size() == 0 || seq1 !== e.s1 || seq2 !== e.s2 || operation_id !== model_id) begin
        errors++;
        $display("[TB] FAIL %s_fields: got seq1=%0d seq2=%0d id=%0d required seq1=%0d seq2=%0d id=%0d",
                 tag, seq1, seq2, operation_id, e.s1, e.s2, model_id);
      end
    end
    repeat (delay) step();
    assign_valid = 1; selected_bank = bank;
    step();
    assign_valid = 0;
    if (exp_req_q.size() > 0) d = exp_req_q.pop_front();
    bank_of[int'(model_id)] = bank;
    model_id = (model_id == 8'hFF) ? 8'd1 : model_id + 8'd1;
  endtask

  task automatic retire(input logic [7:0] id, input string tag);
    bit    seen;
    done_t e;
    op_done = 1; op_done_id = id;
    e.id = id; e.bank = bank_of.exists(int'(id)) ? bank_of[int'(id)] : 3'd0;
    exp_done_q.push_back(e);
    step();
    op_done = 0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (done_valid) begin
        seen = 1;
        break;
      end
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_done: done_valid=0 required 1", tag);
    end else begin
      e = exp_done_q.pop_front();
      if (done_id !== e.id || done_bank !== e.bank) begin
        errors++;
        $display("[TB] FAIL %s_done_fields: got id=%0d bank=%0d required id=%0d bank=%0d",
                 tag, done_id, done_bank, e.id, e.bank);
      end
    end
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    do_reset();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_cmd_ready: got %0b required 1", cmd_ready);
    end
    checks++;
    if ({new_op_request, done_valid, busy, err_unknown_id, err_timeout} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got req=%0b dv=%0b busy=%0b eu=%0b et=%0b required all 0",
               new_op_request, done_valid, busy, err_unknown_id, err_timeout);
    end
    checks++;
    if (outstanding !== 3'd0 || operation_id !== 8'd0 || seq1 !== 8'd0 || seq2 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got out=%0d id=%0d seq1=%0d seq2=%0d required all 0",
               outstanding, operation_id, seq1, seq2);
    end
  endtask

  task automatic test_basic;
    $display("[TB] test_basic");
    do_reset();
    push_cmd(8'd8, 16'd3);
    issue_and_assign(3'd0, 1, "basic");
    checks++;
    if (outstanding !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_outstanding: got out=%0d busy=%0b required 1 1", outstanding, busy);
    end
    retire(8'd1, "basic");
    checks++;
    if (outstanding !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_retired: got out=%0d busy=%0b required 0 0", outstanding, busy);
    end
    step();
    checks++;
    if (done_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_done_pulse: got done_valid=%0b required 0", done_valid);
    end
  endtask

  task automatic test_stall;
    bit bad;
    $display("[TB] test_stall");
    do_reset();
    stall = 1;
    push_cmd(8'd20, 16'd2);
    bad = 0;
    repeat (5) begin
      step();
      if (new_op_request) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL stall_hold: got request while stalled required none");
    end
    stall = 0;
    step();
    checks++;
    if (new_op_request !== 1'b1 || operation_id !== 8'd1) begin
      errors++;
      $display("[TB] FAIL stall_release: got req=%0b id=%0d required req=1 id=1", new_op_request, operation_id);
    end
    issue_and_assign(3'd2, 0, "stall");
  endtask

  task automatic test_back_to_back;
    bit   bad, seen;
    int   prev;
    cmd_t e;
    cmd_t d;
    done_t de;
    $display("[TB] test_back_to_back");
    do_reset();
    stall = 1;
    for (int k = 0; k < 4; k++) push_cmd(8'(k + 1), 16'(10 * k));
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_full: got cmd_ready=%0b required 0", cmd_ready);
    end
    stall = 0;
    for (int k = 0; k < 4; k++) begin
      prev = last_req_cyc;
      issue_and_assign(3'(k), 1, "b2b");
      if (k > 0) begin
        checks++;
        if (last_req_cyc - prev !== 3) begin
          errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles required 3", last_req_cyc - prev);
        end
      end
    end
    checks++;
    if (outstanding !== 3'd4) begin
      errors++; $display("[TB] FAIL b2b_outstanding: got %0d required 4", outstanding);
    end
    push_cmd(8'd9, 16'd9);
    bad = 0;
    repeat (10) begin
      step();
      if (new_op_request) bad = 1;
    end
    checks++;
    if (bad || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_limit: got request=%0b busy=%0b required 0 1", bad, busy);
    end
    retire(8'd2, "b2b_id2");
    issue_and_assign(3'd5, 1, "b2b_id5");
    checks++;
    if (outstanding !== 3'd4) begin
      errors++; $display("[TB] FAIL b2b_id5_out: got %0d required 4", outstanding);
    end
    retire(8'd1, "b2b_id1");
    push_cmd(8'd11, 16'd12);
    wait_req(seen);
    e.s1 = 0; e.s2 = 0;
    if (exp_req_q.size() > 0) e = exp_req_q[0];
    checks++;
    if (!seen || operation_id !== model_id || seq1 !== e.s1 || seq2 !== e.s2) begin
      errors++;
      $display("[TB] FAIL simul_req: got req=%0b id=%0d seq1=%0d required req=1 id=%0d seq1=%0d",
               seen, operation_id, seq1, model_id, e.s1);
    end
    assign_valid = 1; selected_bank = 3'd6;
    op_done = 1; op_done_id = 8'd3;
    de.id = 8'd3; de.bank = bank_of[3];
    exp_done_q.push_back(de);
    step();
    assign_valid = 0; op_done = 0;
    if (exp_req_q.size() > 0) d = exp_req_q.pop_front();
    bank_of[int'(model_id)] = 3'd6;
    model_id = model_id + 8'd1;
    checks++;
    if (outstanding !== 3'd3) begin
      errors++; $display("[TB] FAIL simul_outstanding: got %0d required 3", outstanding);
    end
    de = exp_done_q.pop_front();
    checks++;
    if (done_valid !== 1'b1 || done_id !== de.id || done_bank !== de.bank) begin
      errors++;
      $display("[TB] FAIL simul_done: got dv=%0b id=%0d bank=%0d required dv=1 id=%0d bank=%0d",
               done_valid, done_id, done_bank, de.id, de.bank);
    end
    retire(8'd6, "simul_id6");
  endtask

  task automatic test_timeout;
    bit seen;
    $display("[TB] test_timeout");
    do_reset();
    push_cmd(8'd5, 16'd7);
    wait_req(seen);
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL timeout_req: new_op_request=0 required 1");
    end
    repeat (16) step();
    checks++;
    if (err_timeout !== 1'b0 || new_op_request !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_early: got et=%0b req=%0b required 0 0", err_timeout, new_op_request);
    end
    step();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_flag: got err_timeout=%0b required 1", err_timeout);
    end
    step();
    checks++;
    if (new_op_request !== 1'b1 || operation_id !== 8'd1) begin
      errors++;
      $display("[TB] FAIL timeout_retry: got req=%0b id=%0d required req=1 id=1", new_op_request, operation_id);
    end
    step();
    stall = 1;
    step();
    checks++;
    if (new_op_request !== 1'b0) begin
      errors++; $display("[TB] FAIL reject_backoff: got req=%0b required 0", new_op_request);
    end
    stall = 0;
    step();
    checks++;
    if (new_op_request !== 1'b1 || operation_id !== 8'd1) begin
      errors++;
      $display("[TB] FAIL reject_retry: got req=%0b id=%0d required req=1 id=1", new_op_request, operation_id);
    end
    issue_and_assign(3'd4, 0, "timeout");
    checks++;
    if (outstanding !== 3'd1 || err_timeout !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_final: got out=%0d et=%0b required 1 1", outstanding, err_timeout);
    end
  endtask

  task automatic test_unknown_id;
    $display("[TB] test_unknown_id");
    do_reset();
    op_done = 1; op_done_id = 8'h77;
    step();
    op_done = 0;
    checks++;
    if (err_unknown_id !== 1'b1 || outstanding !== 3'd0 || done_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unknown_id: got eu=%0b out=%0d dv=%0b required 1 0 0", err_unknown_id, outstanding, done_valid);
    end
    step();
    checks++;
    if (err_unknown_id !== 1'b1 || done_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL unknown_sticky: got eu=%0b dv=%0b required 1 0", err_unknown_id, done_valid);
    end
  endtask

  task automatic test_wrap_and_reset;
    bit seen;
    $display("[TB] test_wrap_and_reset");
    do_reset();
    for (int i = 1; i <= 254; i++) begin
      push_cmd(i[7:0], 16'(i));
      issue_and_assign(i[2:0], 0, "wrap_loop");
      retire(i[7:0], "wrap_loop");
    end
    push_cmd(8'd1, 16'd1);
    issue_and_assign(3'd1, 0, "wrap_id255");
    push_cmd(8'd2, 16'd2);
    issue_and_assign(3'd2, 0, "wrap_id1");
    push_cmd(8'd3, 16'd3);
    wait_req(seen);
    step();
    #2 reset = 1;
    #1;
    checks++;
    if (new_op_request !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || outstanding !== 3'd0 ||
        operation_id !== 8'd0 || done_valid !== 1'b0 || err_timeout !== 1'b0 || err_unknown_id !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset: got req=%0b rdy=%0b busy=%0b out=%0d id=%0d required 0 1 0 0 0",
               new_op_request, cmd_ready, busy, outstanding, operation_id);
    end
    @(posedge clk);
    #1;
    reset = 0;
    model_clear();
    push_cmd(8'd4, 16'd4);
    issue_and_assign(3'd3, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_unknown_id();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
